// File: rtl/simon_sequencer_if.sv
// simon_sequencer_if: player/display-side signals of the Simon game controller
interface simon_sequencer_if;
  logic       start;
  logic [2:0] level;
  logic [3:0] key_pulse;
  logic [1:0] state;
  logic [3:0] show_color;
  logic [4:0] round;
  logic       win;
  logic       lose;
  modport master (output start, level, key_pulse, input state, show_color, round, win, lose);
  modport slave  (input start, level, key_pulse, output state, show_color, round, win, lose);
endinterface

// File: rtl/simon_sequencer.sv
// simon_sequencer: grows a random colour sequence, plays it back, then checks the player's presses
module simon_sequencer #(
  parameter int         MAX_LEN  = 16,
  parameter int         TICK_DIV = 5_000_000,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input logic               CLOCK_50,
  input logic               reset,
  simon_sequencer_if.slave  bus
);
  localparam int TW = $clog2(8 * TICK_DIV * 5 + 1);
  localparam logic [2:0] IDLE = 3'd0, ADD = 3'd1, SON = 3'd2, SOFF = 3'd3, USER = 3'd4, WIN = 3'd5, LOSE = 3'd6;
  logic [2:0]    fsm, nxt, lq;
  logic [7:0]    lfsr;
  logic [4:0]    idx;
  logic [TW-1:0] tmr, dur;
  logic [1:0]    mem [32];
  logic          done, tout, last, full, press, good;
  assign dur   = TW'(TICK_DIV) * TW'(3'd6 - lq);
  assign done  = tmr == dur - TW'(1);
  assign tout  = tmr == (dur << 3) - TW'(1);
  assign last  = idx == bus.round - 5'd1;
  assign full  = {1'b0, bus.round} == 6'(MAX_LEN);
  assign press = |bus.key_pulse;
  assign good  = bus.key_pulse == (4'b0001 << mem[idx]);
  always_comb begin
    nxt = fsm;
    case (fsm)
      IDLE, WIN, LOSE: nxt = bus.start ? ADD : fsm;
      ADD:             nxt = SON;
      SON:             nxt = done ? SOFF : SON;
      SOFF:            nxt = !done ? SOFF : last ? USER : SON;
      USER:            nxt = press ? (!good ? LOSE : !last ? USER : full ? WIN : ADD) : tout ? LOSE : USER;
      default:         nxt = IDLE;
    endcase
  end
  // no reset on the sequence memory; it is always written before being read
  always_ff @(posedge CLOCK_50)
    if (fsm == ADD) mem[bus.round] <= lfsr[1:0];
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      fsm            <= IDLE;
      lfsr           <= SEED;
      lq             <= 3'd1;
      idx            <= '0;
      tmr            <= '0;
      bus.state      <= 2'd0;
      bus.show_color <= 4'd0;
      bus.round      <= 5'd0;
      bus.win        <= 1'b0;
      bus.lose       <= 1'b0;
    end else begin
      fsm       <= nxt;
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      bus.state <= nxt == IDLE ? 2'd0 : nxt == USER ? 2'd2 : nxt >= WIN ? 2'd3 : 2'd1;
      bus.win   <= nxt == WIN;
      bus.lose  <= nxt == LOSE;
      tmr       <= (nxt != fsm || (fsm == USER && good)) ? '0 :
                   (fsm == SON || fsm == SOFF || fsm == USER) ? tmr + TW'(1) : tmr;
      case (fsm)
        IDLE, WIN, LOSE: begin
          bus.show_color <= 4'd0;
          if (bus.start) begin
            bus.round <= 5'd0;
            lq        <= (bus.level == 3'd0 || bus.level > 3'd5) ? 3'd1 : bus.level;
          end
        end
        ADD: begin
          bus.round      <= bus.round + 5'd1;
          idx            <= '0;
          // first entry is being written this very cycle, so bypass the memory
          bus.show_color <= 4'b0001 << (bus.round == 5'd0 ? lfsr[1:0] : mem[0]);
        end
        SON:  if (done) bus.show_color <= 4'd0;
        SOFF: if (done) begin
          idx            <= last ? '0 : idx + 5'd1;
          bus.show_color <= last ? 4'd0 : 4'b0001 << mem[idx + 5'd1];
        end
        USER: begin
          bus.show_color <= bus.key_pulse;
          if (good && !last) idx <= idx + 5'd1;
        end
        default: bus.show_color <= 4'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: scoreboard bench; expected colours derive from an LFSR model seeded 8'hA5
module tb_simon_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] mlfsr;
  int n_chk = 0, n_fail = 0, d = 4;
  int seq[$];
  int exp_q[$];
  always #5 clk = ~clk;
  simon_sequencer_if bus();
  simon_sequencer #(.MAX_LEN(3), .TICK_DIV(4), .SEED(8'hA5)) dut (.CLOCK_50(clk), .reset(rst), .bus(bus));
  always @(posedge clk or posedge rst)
    mlfsr <= rst ? 8'hA5 : {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_start(int lvl);
    bus.start = 1'b1;
    bus.level = 3'(lvl);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    seq.delete();
    d = 4 * (6 - ((lvl == 0 || lvl > 5) ? 1 : lvl));
    chk("start_round", bus.round, 0);
  endtask
  task automatic playback(bit noise);
    int on, dk, e;
    chk("add_state", bus.state, 1);
    seq.push_back(int'(mlfsr[1:0]));
    foreach (seq[i]) exp_q.push_back(1 << seq[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      bus.key_pulse = noise ? 4'($urandom_range(1, 15)) : 4'd0;
      chk("show", bus.show_color, e);
      on = 1;
      repeat (d - 1) begin
        @(negedge clk);
        if (bus.show_color == 4'(e)) on++;
        bus.key_pulse = noise ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      chk("on_len", on, d);
      dk = 0;
      repeat (d) begin
        @(negedge clk);
        if (bus.show_color == 4'd0) dk++;
        bus.key_pulse = noise ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      chk("dark_len", dk, d);
    end
    @(negedge clk);
    bus.key_pulse = 4'd0;
    chk("user_state", bus.state, 2);
    chk("round", bus.round, seq.size());
  endtask
  task automatic press(int k);
    bus.key_pulse = 4'(k);
    @(posedge clk);
    @(negedge clk);
    bus.key_pulse = 4'd0;
    chk("echo", bus.show_color, k);
  endtask
  task automatic press_all();
    foreach (seq[i]) press(1 << seq[i]);
  endtask
  initial begin
    int cnt;
    bus.start = 1'b0;
    bus.level = 3'd0;
    bus.key_pulse = 4'd0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_show", bus.show_color, 0);
    chk("rst_round", bus.round, 0);
    chk("rst_win", bus.win, 0);
    chk("rst_lose", bus.lose, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_hold", bus.state, 0);
    do_start(5);
    playback(1'b1);
    press_all();
    playback(1'b0);
    press_all();
    playback(1'b0);
    press_all();
    chk("win", bus.win, 1);
    chk("win_state", bus.state, 3);
    chk("win_lose", bus.lose, 0);
    do_start(5);
    playback(1'b0);
    press_all();
    playback(1'b0);
    press(1 << seq[0]);
    press(1 << ((seq[1] + 1) % 4));
    chk("wrong_lose", bus.lose, 1);
    chk("wrong_state", bus.state, 3);
    chk("wrong_win", bus.win, 0);
    do_start(5);
    playback(1'b0);
    cnt = 0;
    while (!bus.lose && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", cnt, 32);
    do_start(0);
    playback(1'b0);
    press(3);
    chk("multihot_lose", bus.lose, 1);
    do_start(5);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_state", bus.state, 0);
    chk("async_show", bus.show_color, 0);
    chk("async_round", bus.round, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_state", bus.state, 0);
    chk("post_rst_round", bus.round, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
